// File: rtl/dct_pkg.sv
// Shared constants and the cosine lookup for the 8-point DCT.
// The row stage and the column stage both use this package.
package dct_pkg;

  localparam int PIX_W  = 8;
  localparam int OUT_W  = 18;
  localparam int COEF_W = 8;

  // round(64*cos(m*pi/16)) for m = 0..7
  localparam logic [COEF_W-1:0] COS_MAG [8] = '{
    8'd64, 8'd63, 8'd59, 8'd53, 8'd45, 8'd36, 8'd24, 8'd12
  };

  // C[k][n] = round(64*cos((2n+1)*k*pi/16)).
  // The angle is folded into 0..pi, then mirrored about pi/2 to reach the magnitude table.
  function automatic logic signed [COEF_W-1:0] dct_coef(input logic [2:0] k,
                                                         input logic [2:0] n);
    int m;
    m = ((2 * int'(n) + 1) * int'(k)) % 32;
    if (m > 16) m = 32 - m;
    if (m < 8)
      return $signed(COS_MAG[3'(m)]);
    else if (m == 8)
      return '0;
    else
      return -$signed(COS_MAG[3'(16 - m)]);
  endfunction

endpackage

// File: rtl/dct_mac_lane.sv
// One DCT output lane: coefficient lookup for row K, multiply, accumulate.
// The combinational sum includes the current pixel so the last column can be captured directly.
module dct_mac_lane
  import dct_pkg::*;
#(
  parameter int K     = 0,
  parameter int X_W   = PIX_W + 1,
  parameter int C_W   = COEF_W,
  parameter int ACC_W = OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              n,
  input  logic signed [X_W-1:0]   x,
  output logic signed [ACC_W-1:0] sum
);

  localparam int P_W = X_W + C_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [C_W-1:0]   c;
  logic signed [P_W-1:0]   prod;

  assign c = C_W'(dct_coef(3'(K), n));

  always_comb begin
    // Column 0 starts a fresh row, so the stale accumulator is ignored rather than cleared.
    base = (n == 3'd0) ? '0 : acc;
    prod = P_W'(x) * P_W'(c);
    sum  = base + ACC_W'(prod);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= sum;
  end

endmodule

// File: rtl/row_dct8.sv
// Row pass of an 8x8 DCT: streams raster pixels in, emits one row of eight
// coefficients per eight accepted pixels, with a one-row holding register for backpressure.
module row_dct8 #(
  parameter int PIX_W  = dct_pkg::PIX_W,
  parameter int OUT_W  = dct_pkg::OUT_W,
  parameter int COEF_W = dct_pkg::COEF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic signed [OUT_W-1:0] y [8],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_row
);

  localparam logic signed [PIX_W:0] MID = (PIX_W + 1)'(1 << (PIX_W - 1));

  logic [2:0]              n;
  logic [2:0]              row;
  logic                    accept;
  logic                    last;
  logic signed [PIX_W:0]   x;
  logic signed [OUT_W-1:0] sum [8];

  // Only the row-closing pixel must wait; columns 0..6 keep flowing while a row is held.
  assign pix_ready = !(n == 3'd7 && out_valid && !out_ready);
  assign accept    = pix_valid && pix_ready;
  assign last      = accept && (n == 3'd7);
  assign x         = $signed({1'b0, pix_in}) - MID;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    dct_mac_lane #(
      .K     (k),
      .X_W   (PIX_W + 1),
      .C_W   (COEF_W),
      .ACC_W (OUT_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .n   (n),
      .x   (x),
      .sum (sum[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n   <= 3'd0;
      row <= 3'd0;
    end else if (accept) begin
      n <= n + 3'd1;
      if (last)
        row <= row + 3'd1;
    end
  end

  // NOTE: the output row is a small register bank, not a RAM, so it is reset like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '{default: '0};
      out_valid <= 1'b0;
      out_row   <= 3'd0;
    end else if (last) begin
      y         <= sum;
      out_valid <= 1'b1;
      out_row   <= row;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_row_dct8.sv
// Directed bench for row_dct8: table of rows with hand-computed coefficients,
// plus sequences for gaps, streaming, backpressure and mid-row reset.
module tb_row_dct8;

  typedef struct {
    string      name;
    logic [7:0] pix   [8];
    int         exp_y [8];
  } vec_t;

  logic              clk;
  logic              rst;
  logic [7:0]        pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic signed [17:0] y [8];
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_row;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t vecs [5];

  row_dct8 dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Present one pixel and return #1 after the edge that accepted it.
  task automatic push(input logic [7:0] p);
    int waited = 0;
    pix_in    = p;
    pix_valid = 1'b1;
    @(negedge clk);
    while (!pix_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!pix_ready) check("pix_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [7:0] p [8], input int max_gap, input bit keep_valid);
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) begin
        int gap = $urandom_range(max_gap, 0);
        pix_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      push(p[i]);
    end
    if (!keep_valid) pix_valid = 1'b0;
  endtask

  task automatic check_row(input string name, input int exp_y [8], input int exp_row);
    check({name, ".out_valid"}, out_valid, 1);
    check({name, ".out_row"}, out_row, exp_row);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s.y[%0d]", name, k), y[k], exp_y[k]);
  endtask

  task automatic check_cleared(input string name);
    check({name, ".out_valid"}, out_valid, 0);
    check({name, ".out_row"}, out_row, 0);
    check({name, ".pix_ready"}, pix_ready, 1);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s.y[%0d]", name, k), y[k], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{name: "all255", pix: '{default: 8'd255},
                exp_y: '{65024, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{name: "all0", pix: '{default: 8'd0},
                exp_y: '{-65536, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{name: "imp_col0",
                pix: '{8'd129, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128},
                exp_y: '{64, 63, 59, 53, 45, 36, 24, 12}};
    vecs[3] = '{name: "imp_col1",
                pix: '{8'd128, 8'd129, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128},
                exp_y: '{64, 53, 24, -12, -45, -63, -59, -36}};
    vecs[4] = '{name: "neg_col7",
                pix: '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd127},
                exp_y: '{-64, 63, -59, 53, -45, 36, -24, 12}};

    rst       = 1'b1;
    pix_in    = 8'd0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    check("during_reset.pix_ready", pix_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("after_reset");

    // Table rows: latency one cycle after the 8th accept, row index counts up.
    for (int i = 0; i < 5; i++) begin
      send_row(vecs[i].pix, 0, 1'b0);
      check_row(vecs[i].name, vecs[i].exp_y, i);
      @(posedge clk);
      #1;
      check({vecs[i].name, ".valid_drop"}, out_valid, 0);
    end

    // Random pixel gaps must not disturb accumulation.
    for (int i = 0; i < 2; i++) begin
      send_row(vecs[3 + i].pix, 3, 1'b0);
      check_row({"gap_", vecs[3 + i].name}, vecs[3 + i].exp_y, 5 + i);
      @(posedge clk);
      #1;
    end

    // Nine rows streamed with pix_valid held high: out_row 0..7 then 0.
    do_reset();
    for (int r = 0; r < 9; r++) begin
      send_row(vecs[r % 5].pix, 0, 1'b1);
      check_row($sformatf("stream%0d", r), vecs[r % 5].exp_y, r % 8);
    end
    pix_valid = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure: second row waits at its last column until out_ready rises.
    do_reset();
    out_ready = 1'b0;
    send_row(vecs[0].pix, 0, 1'b0);
    check_row("bp_first", vecs[0].exp_y, 0);
    for (int i = 0; i < 7; i++) push(vecs[2].pix[i]);
    pix_in    = vecs[2].pix[7];
    pix_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d.pix_ready", c), pix_ready, 0);
      check($sformatf("bp_hold%0d.out_valid", c), out_valid, 1);
      check($sformatf("bp_hold%0d.out_row", c), out_row, 0);
      check($sformatf("bp_hold%0d.y0", c), y[0], 65024);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    check_row("bp_second", vecs[2].exp_y, 1);
    @(posedge clk);
    #1;
    check("bp_second.valid_drop", out_valid, 0);

    // Reset in the middle of a row while a completed row is being held.
    out_ready = 1'b0;
    send_row(vecs[3].pix, 0, 1'b0);
    check_row("pre_reset_row", vecs[3].exp_y, 2);
    for (int i = 0; i < 4; i++) push(vecs[0].pix[i]);
    pix_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_cleared("mid_row_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_row(vecs[2].pix, 0, 1'b0);
    check_row("post_reset_row", vecs[2].exp_y, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
